// File: rtl/clock_set_controller.sv
// clock_set_controller: button-driven RUN/SET_HOURS/SET_MINUTES sequencer with auto-repeat, blink and timeout
module clock_set_controller #(
  parameter int TICK_DIV        = 100000,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100,
  parameter int TIMEOUT_MS      = 10000,
  parameter int BLINK_MS        = 250
) (
  input  logic       CLK100MHZ,
  input  logic       res,
  input  logic       btn_mode,
  input  logic       btn_up,
  output logic       inc_hour,
  output logic       inc_min,
  output logic       clr_sec,
  output logic       run_en,
  output logic [3:0] blank_mask,
  output logic [1:0] mode
);
  typedef enum logic [1:0] {RUN = 2'b00, SET_HOURS = 2'b01, SET_MINUTES = 2'b10} state_t;
  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int HW = $clog2(REPEAT_DELAY_MS + 1);
  localparam int OW = $clog2(TIMEOUT_MS + 1);
  localparam int BW = $clog2(BLINK_MS + 1);
  localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(REPEAT_DELAY_MS - 1);
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(REPEAT_DELAY_MS - REPEAT_RATE_MS);
  localparam logic [OW-1:0] TO_LAST     = OW'(TIMEOUT_MS - 1);
  localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_MS - 1);
  state_t state, n_state;
  logic [TW-1:0] tick_cnt;
  logic [HW-1:0] hold_cnt, n_hold;
  logic [OW-1:0] to_cnt, n_to;
  logic [BW-1:0] blink_cnt, n_blink;
  logic prev_mode, prev_up, hold_on, n_hold_on, phase, n_phase, n_clr, strobe;
  logic tick, mode_p, up_p, in_set, rep, tout;
  assign tick   = tick_cnt == TICK_LAST;
  assign mode_p = btn_mode & ~prev_mode;
  assign up_p   = btn_up & ~prev_up;
  assign in_set = state != RUN;
  assign rep    = hold_on & btn_up & tick & (hold_cnt == HOLD_LAST);
  assign tout   = in_set & tick & (to_cnt == TO_LAST);
  // next-state: mode press beats up press/repeat, which beat the inactivity timeout
  always_comb begin
    n_state   = state;
    n_hold_on = hold_on;
    n_hold    = hold_cnt;
    n_to      = to_cnt;
    n_blink   = blink_cnt;
    n_phase   = phase;
    n_clr     = 1'b0;
    strobe    = 1'b0;
    if (in_set && tick) begin
      n_to    = to_cnt + 1'b1;
      n_blink = blink_cnt == BLINK_LAST ? '0 : blink_cnt + 1'b1;
      n_phase = phase ^ (blink_cnt == BLINK_LAST);
    end
    if (!btn_up) begin
      n_hold_on = 1'b0;
      n_hold    = '0;
    end else if (hold_on && tick) n_hold = hold_cnt + 1'b1;
    if (mode_p) begin
      n_state   = state == RUN ? SET_HOURS : state == SET_HOURS ? SET_MINUTES : RUN;
      n_clr     = state == RUN;
      n_hold_on = 1'b0;
      n_hold    = '0;
      n_to      = '0;
      n_blink   = '0;
      n_phase   = 1'b0;
    end else if (in_set && (up_p || rep)) begin
      strobe    = 1'b1;
      n_hold_on = 1'b1;
      n_hold    = up_p ? '0 : HOLD_RELOAD;
      n_to      = '0;
      n_blink   = '0;
      n_phase   = 1'b0;
    end else if (tout) begin
      n_state   = RUN;
      n_hold_on = 1'b0;
      n_hold    = '0;
    end
  end
  // state, counters and registered outputs
  always_ff @(posedge CLK100MHZ or posedge res) begin
    if (res) begin
      state      <= RUN;
      tick_cnt   <= '0;
      hold_cnt   <= '0;
      to_cnt     <= '0;
      blink_cnt  <= '0;
      hold_on    <= 1'b0;
      phase      <= 1'b0;
      prev_mode  <= 1'b0;
      prev_up    <= 1'b0;
      inc_hour   <= 1'b0;
      inc_min    <= 1'b0;
      clr_sec    <= 1'b0;
      run_en     <= 1'b1;
      blank_mask <= 4'b0000;
      mode       <= 2'b00;
    end else begin
      state      <= n_state;
      tick_cnt   <= tick ? '0 : tick_cnt + 1'b1;
      hold_cnt   <= n_hold;
      to_cnt     <= n_to;
      blink_cnt  <= n_blink;
      hold_on    <= n_hold_on;
      phase      <= n_phase;
      prev_mode  <= btn_mode;
      prev_up    <= btn_up;
      inc_hour   <= strobe && state == SET_HOURS;
      inc_min    <= strobe && state == SET_MINUTES;
      clr_sec    <= n_clr;
      run_en     <= n_state == RUN;
      blank_mask <= n_state == SET_HOURS ? {n_phase, n_phase, 2'b00} :
                    n_state == SET_MINUTES ? {2'b00, n_phase, n_phase} : 4'b0000;
      mode       <= n_state;
    end
  end
endmodule

// File: tb/tb_clock_set_controller.sv
// tb_clock_set_controller: directed + random stimulus against a time-arithmetic reference model
module tb_clock_set_controller;
  localparam int TD = 4, RD = 5, RR = 2, TO = 20, BL = 3;
  logic CLK100MHZ = 1'b0, res = 1'b1, btn_mode = 1'b0, btn_up = 1'b0;
  logic inc_hour, inc_min, clr_sec, run_en;
  logic [3:0] blank_mask;
  logic [1:0] mode;
  int compared = 0, mismatched = 0;
  int e, ms, act_ms, blink_ms, hold_ms, m_mode, n_ih, n_im;
  bit holding, pm, pu;
  logic x_ih, x_im, x_cs;

  clock_set_controller #(.TICK_DIV(TD), .REPEAT_DELAY_MS(RD), .REPEAT_RATE_MS(RR),
                         .TIMEOUT_MS(TO), .BLINK_MS(BL)) dut (
    .CLK100MHZ(CLK100MHZ), .res(res), .btn_mode(btn_mode), .btn_up(btn_up),
    .inc_hour(inc_hour), .inc_min(inc_min), .clr_sec(clr_sec), .run_en(run_en),
    .blank_mask(blank_mask), .mode(mode));

  always #5 CLK100MHZ = ~CLK100MHZ;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, got, exp, e);
    end
  endtask

  task automatic model_reset();
    e = 0; ms = 0; act_ms = 0; blink_ms = 0; hold_ms = 0; m_mode = 0;
    holding = 0; pm = 0; pu = 0;
  endtask

  // one clock edge of the reference: time measured in elapsed ms ticks since reset
  task automatic model_edge(input logic bm, input logic bu);
    bit tick, mp, upp;
    int k;
    e++;
    tick = (e % TD) == 0;
    if (tick) ms++;
    x_ih = 0; x_im = 0; x_cs = 0;
    mp = bm && !pm;
    upp = bu && !pu;
    pm = bm; pu = bu;
    if (!bu) holding = 0;
    k = ms - hold_ms;
    if (mp) begin
      x_cs = m_mode == 0;
      m_mode = (m_mode + 1) % 3;
      holding = 0; act_ms = ms; blink_ms = ms;
    end else if (m_mode != 0 && upp) begin
      x_ih = m_mode == 1; x_im = m_mode == 2;
      holding = 1; hold_ms = ms; act_ms = ms; blink_ms = ms;
    end else if (m_mode != 0 && holding && tick && k >= RD && (k - RD) % RR == 0) begin
      x_ih = m_mode == 1; x_im = m_mode == 2;
      act_ms = ms; blink_ms = ms;
    end else if (m_mode != 0 && tick && ms - act_ms == TO) begin
      m_mode = 0; holding = 0;
    end
  endtask

  task automatic check_all();
    logic ph;
    logic [3:0] xb;
    ph = ((ms - blink_ms) / BL) % 2 == 1;
    xb = m_mode == 1 ? {ph, ph, 2'b00} : m_mode == 2 ? {2'b00, ph, ph} : 4'b0000;
    chk("inc_hour", inc_hour, x_ih);
    chk("inc_min", inc_min, x_im);
    chk("clr_sec", clr_sec, x_cs);
    chk("run_en", run_en, m_mode == 0);
    chk("mode", mode, m_mode);
    chk("blank_mask", blank_mask, xb);
  endtask

  // called at a negedge; returns at the next negedge
  task automatic step(input logic bm, input logic bu);
    btn_mode = bm; btn_up = bu;
    @(posedge CLK100MHZ);
    model_edge(bm, bu);
    #1;
    check_all();
    n_ih += int'(inc_hour);
    n_im += int'(inc_min);
    @(negedge CLK100MHZ);
  endtask

  task automatic reset_values(input string tag);
    chk({tag, "_inc_hour"}, inc_hour, 1'b0);
    chk({tag, "_inc_min"}, inc_min, 1'b0);
    chk({tag, "_clr_sec"}, clr_sec, 1'b0);
    chk({tag, "_run_en"}, run_en, 1'b1);
    chk({tag, "_mode"}, mode, 2'b00);
    chk({tag, "_blank"}, blank_mask, 4'b0000);
  endtask

  initial begin
    int len, guard;
    logic bu, bm;
    repeat (3) @(posedge CLK100MHZ);
    #1 reset_values("por");
    @(negedge CLK100MHZ);
    res = 1'b0;
    model_reset();
    n_ih = 0; n_im = 0;
    for (int i = 0; i < 200; i++) step(1'b0, 1'($urandom_range(0, 1)));
    chk("run_idle_inc", n_ih + n_im, 0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    n_ih = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
    end
    chk("three_presses", n_ih, 3);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    n_im = 0;
    for (int i = 0; i < 60; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
    chk("hold_repeat_min", n_im >= 5, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("back_to_run", mode, 2'b00);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 120; i++) step(1'b0, 1'b0);
    chk("timeout_mode", mode, 2'b00);
    chk("timeout_run_en", run_en, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    n_ih = 0; n_im = 0;
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1);
    chk("simul_mode", mode, 2'b10);
    chk("simul_no_inc", n_ih + n_im, 0);
    step(1'b0, 1'b0);
    for (int s = 0; s < 70; s++) begin
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 110) : $urandom_range(1, 40);
      bu = 1'($urandom_range(0, 1));
      bm = $urandom_range(0, 4) == 0;
      for (int i = 0; i < len; i++) step(bm && i < 2, bu);
    end
    guard = 0;
    while (m_mode != 2 && guard < 4) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      guard++;
    end
    chk("reach_set_min", mode, 2'b10);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1);
    #2 res = 1'b1;
    #1 reset_values("async");
    model_reset();
    @(negedge CLK100MHZ);
    @(negedge CLK100MHZ);
    res = 1'b0;
    n_ih = 0; n_im = 0;
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    chk("post_reset_no_inc", n_ih + n_im, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
